nibble_parity_tx: RTL and testbench



---
 rtl/nibble_parity_tx_if.sv | 9 +
 rtl/nibble_parity_tx.sv | 124 ++++++++++++
 tb/tb_nibble_parity_tx.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_parity_tx_if.sv
// Valid/ready nibble handshake between the parity generator and the serial transmitter.
interface nibble_parity_tx_if;
    logic [3:0] data_in;
    logic       valid;
    logic       ready;

    modport master (output data_in, output valid, input ready);
    modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/nibble_parity_tx.sv
// Serial transmitter for 4-bit words: start, d0..d3, parity, stop, each bit held CLKS_PER_BIT clocks.
// Optional macro EVEN_PARITY_EN switches the parity bit from odd (default) to even.
module nibble_parity_tx #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    nibble_parity_tx_if.slave   bus,
    output logic                tx_out,
    output logic                busy
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned DATA_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   data_q;
    logic                par_q;
    logic                ready_q;
    logic                par_c;
    logic                bit_done_c;

`ifdef EVEN_PARITY_EN
    assign par_c = ^bus.data_in;
`else
    assign par_c = ~(^bus.data_in);
`endif

    assign bit_done_c = (cnt == CNT_LAST);
    assign bus.ready  = ready_q;

    // Frame sequencer; tx_out is loaded with the next bit value on the edge the state advances.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx_out  <= 1'b1;
            ready_q <= 1'b1;
            busy    <= 1'b0;
            cnt     <= '0;
            idx     <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.valid && ready_q) begin
                        data_q  <= bus.data_in;
                        par_q   <= par_c;
                        state   <= START;
                        tx_out  <= 1'b0;
                        ready_q <= 1'b0;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        idx     <= '0;
                    end
                end
                START: begin
                    if (bit_done_c) begin
                        state  <= DATA;
                        tx_out <= data_q[0];
                        idx    <= '0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_done_c) begin
                        cnt <= '0;
                        if (idx == IDX_W'(3)) begin
                            state  <= PARITY;
                            tx_out <= par_q;
                        end else begin
                            idx    <= idx + IDX_W'(1);
                            tx_out <= data_q[idx + IDX_W'(1)];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_done_c) begin
                        state  <= STOP;
                        tx_out <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_done_c) begin
                        state   <= IDLE;
                        tx_out  <= 1'b1;
                        ready_q <= 1'b1;
                        busy    <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_out  <= 1'b1;
                    ready_q <= 1'b1;
                    busy    <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_parity_tx.sv
// Self-checking bench for nibble_parity_tx: CLKS_PER_BIT=4 instance plus a CLKS_PER_BIT=1 instance.
module tb_nibble_parity_tx;

    localparam int unsigned CPB = 4;

    logic clk;
    logic rst_n;
    logic tx4, busy4;
    logic tx1, busy1;
    int   n_checks;
    int   n_fail;

    nibble_parity_tx_if bus4 ();
    nibble_parity_tx_if bus1 ();

    nibble_parity_tx #(.CLKS_PER_BIT(CPB)) dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus4),
        .tx_out (tx4),
        .busy   (busy4)
    );

    nibble_parity_tx #(.CLKS_PER_BIT(1)) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus1),
        .tx_out (tx1),
        .busy   (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: parity chosen so the count of ones in d0..d3 plus parity is odd (or even with the macro).
    function automatic logic model_parity(input logic [3:0] d);
        int ones;
        ones = 0;
        for (int i = 0; i < 4; i++) ones += int'(d[i]);
`ifdef EVEN_PARITY_EN
        return (ones % 2) == 1;
`else
        return (ones % 2) == 0;
`endif
    endfunction

    // Reference frame: position 0 start, 1..4 data LSB first, 5 parity, 6 stop.
    function automatic logic frame_bit(input logic [3:0] d, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= 4) return d[pos-1];
        if (pos == 5) return model_parity(d);
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus4.valid = 1'b1;
        bus4.data_in = 4'($urandom);
        bus1.valid = 1'b1;
        bus1.data_in = 4'($urandom);
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({tx4, bus4.ready, busy4} !== 3'b110) begin
                n_fail++;
                $display("FAIL reset_cpb4: tx/ready/busy=%b expected 110", {tx4, bus4.ready, busy4});
            end
            n_checks++;
            if ({tx1, bus1.ready, busy1} !== 3'b110) begin
                n_fail++;
                $display("FAIL reset_cpb1: tx/ready/busy=%b expected 110", {tx1, bus1.ready, busy1});
            end
        end
        bus4.valid = 1'b0;
        bus1.valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({tx4, bus4.ready, busy4} !== 3'b110) begin
            n_fail++;
            $display("FAIL reset_release: tx/ready/busy=%b expected 110", {tx4, bus4.ready, busy4});
        end
    endtask

    task automatic test_single_frame(input logic [3:0] d);
        int   busy_cycles;
        logic exp;
        busy_cycles = 0;
        bus4.data_in = d;
        bus4.valid = 1'b1;
        @(negedge clk);
        bus4.valid = 1'b0;
        bus4.data_in = 4'($urandom);
        for (int k = 0; k < int'(7 * CPB); k++) begin
            exp = frame_bit(d, k / int'(CPB));
            n_checks++;
            if (tx4 !== exp) begin
                n_fail++;
                $display("FAIL frame_bit d=%b cycle %0d: tx_out=%b expected %b", d, k, tx4, exp);
            end
            n_checks++;
            if (bus4.ready !== 1'b0) begin
                n_fail++;
                $display("FAIL frame_ready d=%b cycle %0d: ready=%b expected 0", d, k, bus4.ready);
            end
            if (busy4 === 1'b1) busy_cycles++;
            @(negedge clk);
        end
        n_checks++;
        if ({tx4, bus4.ready, busy4} !== 3'b110) begin
            n_fail++;
            $display("FAIL frame_end d=%b: tx/ready/busy=%b expected 110", d, {tx4, bus4.ready, busy4});
        end
        n_checks++;
        if (busy_cycles != int'(7 * CPB)) begin
            n_fail++;
            $display("FAIL busy_len d=%b: busy cycles=%0d expected %0d", d, busy_cycles, 7 * CPB);
        end
    endtask

    task automatic test_ignored_input();
        logic [3:0] d1;
        logic [3:0] d2;
        logic       exp;
        d1 = 4'b1011;
        d2 = 4'b0110;
        bus4.data_in = d1;
        bus4.valid = 1'b1;
        @(negedge clk);
        bus4.valid = 1'b0;
        for (int k = 0; k < int'(7 * CPB); k++) begin
            if (k == 5) begin
                bus4.data_in = d2;
                bus4.valid = 1'b1;
            end
            exp = frame_bit(d1, k / int'(CPB));
            n_checks++;
            if (tx4 !== exp) begin
                n_fail++;
                $display("FAIL ignored_first cycle %0d: tx_out=%b expected %b", k, tx4, exp);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({tx4, bus4.ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL ignored_idle_gap: tx/ready=%b expected 11", {tx4, bus4.ready});
        end
        @(negedge clk);
        bus4.valid = 1'b0;
        for (int k = 0; k < int'(7 * CPB); k++) begin
            exp = frame_bit(d2, k / int'(CPB));
            n_checks++;
            if (tx4 !== exp || busy4 !== 1'b1) begin
                n_fail++;
                $display("FAIL ignored_second cycle %0d: tx/busy=%b%b expected %b1", k, tx4, busy4, exp);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({tx4, bus4.ready, busy4} !== 3'b110) begin
            n_fail++;
            $display("FAIL ignored_end: tx/ready/busy=%b expected 110", {tx4, bus4.ready, busy4});
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [3:0] d;
        logic       exp;
        d = 4'($urandom);
        bus4.data_in = d;
        bus4.valid = 1'b1;
        @(negedge clk);
        bus4.valid = 1'b0;
        for (int k = 0; k <= int'(3 * CPB); k++) begin
            exp = frame_bit(d, k / int'(CPB));
            n_checks++;
            if (tx4 !== exp) begin
                n_fail++;
                $display("FAIL midrst_pre cycle %0d: tx_out=%b expected %b", k, tx4, exp);
            end
            @(negedge clk);
        end
        n_checks++;
        if (tx4 !== d[2] || busy4 !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_bit2: tx/busy=%b%b expected %b1", tx4, busy4, d[2]);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if ({tx4, bus4.ready, busy4} !== 3'b110) begin
            n_fail++;
            $display("FAIL midrst_edge: tx/ready/busy=%b expected 110", {tx4, bus4.ready, busy4});
        end
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if ({tx4, bus4.ready, busy4} !== 3'b110) begin
                n_fail++;
                $display("FAIL midrst_no_resume: tx/ready/busy=%b expected 110", {tx4, bus4.ready, busy4});
            end
        end
        test_single_frame(4'($urandom));
    endtask

    task automatic test_back_to_back();
        logic exp;
        bus1.data_in = 4'b1111;
        bus1.valid = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 7; k++) begin
                exp = frame_bit(4'b1111, k);
                n_checks++;
                if (tx1 !== exp || busy1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b frame %0d bit %0d: tx/busy=%b%b expected %b1", f, k, tx1, busy1, exp);
                end
                @(negedge clk);
            end
            n_checks++;
            if ({tx1, bus1.ready, busy1} !== 3'b110) begin
                n_fail++;
                $display("FAIL b2b_gap frame %0d: tx/ready/busy=%b expected 110", f, {tx1, bus1.ready, busy1});
            end
            if (f == 2) bus1.valid = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if ({tx1, bus1.ready, busy1} !== 3'b110) begin
            n_fail++;
            $display("FAIL b2b_stop: tx/ready/busy=%b expected 110", {tx1, bus1.ready, busy1});
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        bus4.valid = 1'b0;
        bus4.data_in = 4'b0000;
        bus1.valid = 1'b0;
        bus1.data_in = 4'b0000;
        rst_n = 1'b0;
        test_reset();
        test_single_frame(4'b1011);
        test_single_frame(4'b0000);
        for (int i = 0; i < 6; i++) test_single_frame(4'($urandom));
        test_ignored_input();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
